mmio_responder: RTL
===================

Name: mmio_responder

Overview:
- Responder on the CPU load/store memory port (port B), sitting between the CPU and basic_mem.
- Decodes each load/store address:
  - RAM-range accesses pass through to basic_mem port B.
  - IO-range accesses are served from local registers: GPIO, a countdown timer, and a free-running cycle counter.
- Read data returns with the same 1-cycle latency as the synchronous RAM, so the CPU sees one uniform port.

Parameters:
- WIDTH, 16, data/address width.
- IO_BASE, 16'hFF00, first IO address; IO window is IO_BASE..IO_BASE+7.
- GPIO_W, 8, width of gpio_out and gpio_in.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- write_to_memory  in  1  CPU store strobe.
- mem_address_load_stor  in  WIDTH  CPU load/store address.
- data_to_mem_stor  in  WIDTH  CPU store data.
- data_from_mem_load  out  WIDTH  load data returned to CPU.
- ram_we_b  out  1  gated write enable to basic_mem port B.
- ram_q_b  in  WIDTH  basic_mem port B read data (registered in RAM).
- gpio_in  in  GPIO_W  asynchronous external inputs.
- gpio_out  out  GPIO_W  output register.
- timer_irq  out  1  level, equals TIMER_STATUS bit0.

Behaviour:
- Address decode:
  - io_sel = (addr >= IO_BASE) && (addr <= IO_BASE+7), combinational.
  - off = addr - IO_BASE, 3 bits.
- RAM write gating: ram_we_b = write_to_memory & ~io_sel, combinational. IO writes never reach RAM.
- Register map (off):
  - 0 GPIO_OUT: rw.
  - 1 GPIO_IN: ro, 2-flop synchronised, zero-extended.
  - 2 TIMER_LOAD: rw. A write also loads TIMER_COUNT in the same edge.
  - 3 TIMER_COUNT: ro; writes ignored.
  - 4 TIMER_CTRL: rw. bit0 EN, bit1 AUTO; other bits read 0.
  - 5 TIMER_STATUS: bit0 EXP, sticky. Writing 1 to bit0 clears it; writing 0 has no effect.
  - 6 CYCLE: ro, free-running WIDTH-bit counter; wraps FFFF->0000.
  - 7: reserved, reads 0, writes ignored.
- Read path, 1-cycle latency:
  - On each edge, register sel_q <= io_sel and io_rdata_q <= mux(off).
  - data_from_mem_load = sel_q ? io_rdata_q : ram_q_b.
  - Read value = register contents before any same-cycle write (read-before-write, matching RAM).
  - CYCLE read at edge N returns the value held before edge N.
- Timer, evaluated each edge:
  - Priority: TIMER_LOAD write > decrement. A write of LOAD in the same cycle as expiry loads the new value and does not set EXP.
  - When EN=1 and COUNT>1: COUNT <= COUNT-1.
  - When EN=1 and COUNT==1: COUNT <= AUTO ? LOAD : 0, and EXP <= 1.
  - When COUNT==0: no decrement and no new expiry, even if EN=1.
  - When EN=0: COUNT holds.
  - Set wins over clear: if an EXP write-1-clear and an expiry occur in the same cycle, EXP stays 1.
  - AUTO with LOAD==1: expires every cycle.
- GPIO_IN sync:
  - gpio_in -> s1 -> s2.
  - A change is visible in a read 3 edges after the input changes (2 sync edges plus 1 read register edge).
- Reset (synchronous), all to 0: gpio_out, sync flops, LOAD, COUNT, CTRL, EXP, CYCLE, sel_q, io_rdata_q.
  - Therefore data_from_mem_load = ram_q_b and timer_irq = 0 after reset.
  - Reset mid-count aborts the timer. A pending EXP is cleared. Any store in the reset cycle is ignored for IO registers.
  - ram_we_b stays combinational: the RAM side is not gated by reset, and the CPU owns that.

Test Plan:
- Pass-through: store 0x1234 to addr 0x0010 -> ram_we_b=1 that cycle; load 0x0010 -> data_from_mem_load=0x1234 one cycle later. Store to 0xFF00 -> ram_we_b=0.
- GPIO: store 0x00A5 to 0xFF00 -> gpio_out=0xA5 next edge, and load 0xFF00 returns 0x00A5. Set gpio_in=0x3C -> load 0xFF01 returns 0x003C three edges after the change.
- One-shot timer: write LOAD=3, CTRL=1 -> COUNT 3,2,1,0 on successive edges; EXP/timer_irq=1 on the edge COUNT hits 0. COUNT then stays 0. Write 1 to 0xFF05 -> irq=0.
- Auto-reload with collision: LOAD=2, CTRL=3 -> irq set every 2 cycles, COUNT pattern 2,1,2,1. Issue the STATUS clear in an expiry cycle -> EXP remains 1.
- Reset mid-operation: COUNT=5, EN=1, EXP=1, CYCLE≈0x0040, assert reset 1 cycle -> all registers read 0 and irq=0; the CYCLE read right after reset release returns 0x0000 or 0x0001 per the read-before-write rule.
- Reserved and ro addresses: store to 0xFF03 and 0xFF07 -> no state change and no RAM write; load 0xFF07 -> 0x0000.

Source files
------------

// File: rtl/mmio_responder.sv
// Load/store port responder: passes RAM-range accesses to basic_mem port B and
// serves an 8-word IO window (GPIO, countdown timer, cycle counter) with matching 1-cycle read latency.
module mmio_responder #(
  parameter int                WIDTH   = 16,
  parameter logic [WIDTH-1:0]  IO_BASE = 16'hFF00,
  parameter int                GPIO_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              write_to_memory,
  input  logic [WIDTH-1:0]  mem_address_load_stor,
  input  logic [WIDTH-1:0]  data_to_mem_stor,
  output logic [WIDTH-1:0]  data_from_mem_load,
  output logic              ram_we_b,
  input  logic [WIDTH-1:0]  ram_q_b,
  input  logic [GPIO_W-1:0] gpio_in,
  output logic [GPIO_W-1:0] gpio_out,
  output logic              timer_irq
);

  typedef enum logic [2:0] {
    REG_GPIO_OUT     = 3'd0,
    REG_GPIO_IN      = 3'd1,
    REG_TIMER_LOAD   = 3'd2,
    REG_TIMER_COUNT  = 3'd3,
    REG_TIMER_CTRL   = 3'd4,
    REG_TIMER_STATUS = 3'd5,
    REG_CYCLE        = 3'd6,
    REG_RESERVED     = 3'd7
  } reg_off_e;

  logic              io_sel;
  reg_off_e          off;
  logic              io_wr;
  logic              wr_gpio, wr_load, wr_ctrl, wr_status_clr;

  logic [GPIO_W-1:0] gpio_s1, gpio_s2;
  logic [WIDTH-1:0]  load_q, count_q, count_d;
  logic [1:0]        ctrl_q;
  logic              exp_q, exp_d, exp_set;
  logic [WIDTH-1:0]  cycle_q;
  logic              sel_q;
  logic [WIDTH-1:0]  io_rdata_q, io_rdata;

  // Upper bound compared one bit wider so IO_BASE+7 cannot wrap
  assign io_sel = (mem_address_load_stor >= IO_BASE) &&
                  ({1'b0, mem_address_load_stor} <= ({1'b0, IO_BASE} + (WIDTH+1)'(7)));
  assign off    = reg_off_e'(mem_address_load_stor[2:0] - IO_BASE[2:0]);

  assign ram_we_b = write_to_memory & ~io_sel;
  assign io_wr    = write_to_memory & io_sel;

  assign wr_gpio       = io_wr && (off == REG_GPIO_OUT);
  assign wr_load       = io_wr && (off == REG_TIMER_LOAD);
  assign wr_ctrl       = io_wr && (off == REG_TIMER_CTRL);
  assign wr_status_clr = io_wr && (off == REG_TIMER_STATUS) && data_to_mem_stor[0];

  // A LOAD write pre-empts the decrement, so it also suppresses a coincident expiry
  always_comb begin
    count_d = count_q;
    exp_set = 1'b0;
    if (wr_load) begin
      count_d = data_to_mem_stor;
    end else if (ctrl_q[0] && (count_q != '0)) begin
      if (count_q == WIDTH'(1)) begin
        count_d = ctrl_q[1] ? load_q : '0;
        exp_set = 1'b1;
      end else begin
        count_d = count_q - WIDTH'(1);
      end
    end
  end

  assign exp_d = exp_set | (exp_q & ~wr_status_clr);

  always_comb begin
    io_rdata = '0;
    case (off)
      REG_GPIO_OUT:     io_rdata[GPIO_W-1:0] = gpio_out;
      REG_GPIO_IN:      io_rdata[GPIO_W-1:0] = gpio_s2;
      REG_TIMER_LOAD:   io_rdata = load_q;
      REG_TIMER_COUNT:  io_rdata = count_q;
      REG_TIMER_CTRL:   io_rdata[1:0] = ctrl_q;
      REG_TIMER_STATUS: io_rdata[0] = exp_q;
      REG_CYCLE:        io_rdata = cycle_q;
      default:          io_rdata = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      gpio_out   <= '0;
      gpio_s1    <= '0;
      gpio_s2    <= '0;
      load_q     <= '0;
      count_q    <= '0;
      ctrl_q     <= '0;
      exp_q      <= 1'b0;
      cycle_q    <= '0;
      sel_q      <= 1'b0;
      io_rdata_q <= '0;
    end else begin
      gpio_s1    <= gpio_in;
      gpio_s2    <= gpio_s1;
      if (wr_gpio) gpio_out <= data_to_mem_stor[GPIO_W-1:0];
      if (wr_load) load_q <= data_to_mem_stor;
      if (wr_ctrl) ctrl_q <= data_to_mem_stor[1:0];
      count_q    <= count_d;
      exp_q      <= exp_d;
      cycle_q    <= cycle_q + WIDTH'(1);
      sel_q      <= io_sel;
      io_rdata_q <= io_rdata;
    end
  end

  assign data_from_mem_load = sel_q ? io_rdata_q : ram_q_b;
  assign timer_irq          = exp_q;

endmodule
